// File: rtl/mem_wb_stage.sv
// MEM stage + MEM/WB register for the 8-bit TISC core: owns the 256x8 data
// memory, performs stores, resolves loads and registers the write-back slot.
module mem_wb_stage #(
  parameter int DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       flush,
  input  logic [3:0] ireg_write_addr,
  input  logic       ireg_write_en,
  input  logic       imem_to_reg,
  input  logic [7:0] ialu_out,
  input  logic       imem_write_en,
  input  logic [7:0] idata_write_addr,
  input  logic [7:0] idata_write_data,
  input  logic [7:0] idata_read_addr,
  input  logic [7:0] inextPC,
  output logic [3:0] oreg_write_addr,
  output logic       oreg_write_en,
  output logic [7:0] owb_data,
  output logic [7:0] onextPC,
  output logic       ovalid
);

  logic [7:0] mem [DEPTH];
  logic       store_fire;
  logic [7:0] load_data;
  logic [7:0] wb_next;
  logic       load_regs;

  assign store_fire = en && !flush && imem_write_en;
  assign load_regs  = en || flush;

  // Write-first: a store to the address being loaded bypasses the array.
  assign load_data = (store_fire && (idata_write_addr == idata_read_addr))
                     ? idata_write_data : mem[idata_read_addr];
  assign wb_next   = imem_to_reg ? load_data : ialu_out;

  // Memory shares the reset-qualified block so no store lands while in reset;
  // its contents are deliberately left out of the reset branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oreg_write_addr <= '0;
      oreg_write_en   <= 1'b0;
      owb_data        <= '0;
      onextPC         <= '0;
      ovalid          <= 1'b0;
    end else begin
      if (store_fire) mem[idata_write_addr] <= idata_write_data;
      if (load_regs) begin
        oreg_write_addr <= ireg_write_addr;
        owb_data        <= wb_next;
        onextPC         <= inextPC;
      end
      if (flush) begin
        oreg_write_en <= 1'b0;
        ovalid        <= 1'b0;
      end else if (en) begin
        oreg_write_en <= ireg_write_en;
        ovalid        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: store/load, bypass, ALU path, stall, flush, reset.
module tb_mem_wb_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, flush;
  logic [3:0] ireg_write_addr;
  logic       ireg_write_en, imem_to_reg, imem_write_en;
  logic [7:0] ialu_out, idata_write_addr, idata_write_data, idata_read_addr, inextPC;
  logic [3:0] oreg_write_addr;
  logic       oreg_write_en, ovalid;
  logic [7:0] owb_data, onextPC;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .ireg_write_addr(ireg_write_addr), .ireg_write_en(ireg_write_en),
    .imem_to_reg(imem_to_reg), .ialu_out(ialu_out),
    .imem_write_en(imem_write_en), .idata_write_addr(idata_write_addr),
    .idata_write_data(idata_write_data), .idata_read_addr(idata_read_addr),
    .inextPC(inextPC), .oreg_write_addr(oreg_write_addr),
    .oreg_write_en(oreg_write_en), .owb_data(owb_data),
    .onextPC(onextPC), .ovalid(ovalid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one instruction, clock it in, then settle 1ns past the edge.
  task automatic issue(input logic e, input logic f, input logic [3:0] wa, input logic we,
                       input logic m2r, input logic [7:0] alu, input logic mwe,
                       input logic [7:0] swa, input logic [7:0] swd,
                       input logic [7:0] ra, input logic [7:0] pc);
    en = e; flush = f; ireg_write_addr = wa; ireg_write_en = we;
    imem_to_reg = m2r; ialu_out = alu; imem_write_en = mwe;
    idata_write_addr = swa; idata_write_data = swd; idata_read_addr = ra; inextPC = pc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 0; flush = 0; ireg_write_addr = 0; ireg_write_en = 0; imem_to_reg = 0;
    ialu_out = 0; imem_write_en = 0; idata_write_addr = 0; idata_write_data = 0;
    idata_read_addr = 0; inextPC = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr",  32'(oreg_write_addr), 32'h0);
    chk("rst_we",    32'(oreg_write_en),   32'h0);
    chk("rst_wb",    32'(owb_data),        32'h0);
    chk("rst_pc",    32'(onextPC),         32'h0);
    chk("rst_valid", 32'(ovalid),          32'h0);
    rst_n = 1'b1;

    // Pre-write known values used by the stall and flush checks.
    issue(1, 0, 4'd0, 0, 0, 8'h00, 1, 8'h20, 8'h00, 8'h00, 8'h01);
    issue(1, 0, 4'd0, 0, 0, 8'h00, 1, 8'h30, 8'h11, 8'h00, 8'h02);

    // Store then load.
    issue(1, 0, 4'd0, 0, 0, 8'h00, 1, 8'h10, 8'hA5, 8'h00, 8'h03);
    issue(1, 0, 4'd3, 1, 1, 8'h00, 0, 8'h00, 8'h00, 8'h10, 8'h04);
    chk("ld_wb",    32'(owb_data),        32'hA5);
    chk("ld_addr",  32'(oreg_write_addr), 32'h3);
    chk("ld_we",    32'(oreg_write_en),   32'h1);
    chk("ld_valid", 32'(ovalid),          32'h1);
    chk("ld_pc",    32'(onextPC),         32'h04);

    // Write-first bypass, then a later load of the same address.
    issue(1, 0, 4'd5, 1, 1, 8'h99, 1, 8'hFF, 8'h3C, 8'hFF, 8'h05);
    chk("byp_wb", 32'(owb_data), 32'h3C);
    issue(1, 0, 4'd6, 1, 1, 8'h99, 0, 8'h00, 8'h00, 8'hFF, 8'h06);
    chk("byp_later_wb", 32'(owb_data), 32'h3C);

    // ALU path.
    issue(1, 0, 4'd7, 1, 0, 8'h7E, 0, 8'h00, 8'h00, 8'h10, 8'h21);
    chk("alu_wb",   32'(owb_data),        32'h7E);
    chk("alu_pc",   32'(onextPC),         32'h21);
    chk("alu_addr", 32'(oreg_write_addr), 32'h7);

    // Stall with a pending store: outputs hold, store dropped.
    for (int i = 0; i < 3; i++) begin
      issue(0, 0, 4'd9, 0, 1, 8'h44, 1, 8'h20, 8'h55, 8'h20, 8'h33);
      chk("stall_wb",    32'(owb_data),        32'h7E);
      chk("stall_pc",    32'(onextPC),         32'h21);
      chk("stall_addr",  32'(oreg_write_addr), 32'h7);
      chk("stall_valid", 32'(ovalid),          32'h1);
    end
    issue(1, 0, 4'd2, 1, 1, 8'h44, 0, 8'h00, 8'h00, 8'h20, 8'h34);
    chk("stall_mem", 32'(owb_data), 32'h00);

    // Flush: bubble and suppressed store.
    issue(1, 1, 4'd4, 1, 0, 8'h12, 1, 8'h30, 8'h77, 8'h00, 8'h40);
    chk("flush_we",    32'(oreg_write_en), 32'h0);
    chk("flush_valid", 32'(ovalid),        32'h0);
    issue(1, 0, 4'd4, 1, 1, 8'h12, 0, 8'h00, 8'h00, 8'h30, 8'h41);
    chk("flush_mem",   32'(owb_data), 32'h11);
    chk("post_valid",  32'(ovalid),   32'h1);

    // Flush wins over a stall.
    issue(0, 1, 4'd4, 1, 0, 8'h12, 0, 8'h00, 8'h00, 8'h00, 8'h42);
    chk("flush_stall_valid", 32'(ovalid),        32'h0);
    chk("flush_stall_we",    32'(oreg_write_en), 32'h0);

    // Mid-cycle asynchronous reset with nonzero outputs.
    issue(1, 0, 4'd8, 1, 0, 8'hC3, 0, 8'h00, 8'h00, 8'h00, 8'h50);
    chk("pre_rst_wb", 32'(owb_data), 32'hC3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_addr",  32'(oreg_write_addr), 32'h0);
    chk("arst_we",    32'(oreg_write_en),   32'h0);
    chk("arst_wb",    32'(owb_data),        32'h0);
    chk("arst_pc",    32'(onextPC),         32'h0);
    chk("arst_valid", 32'(ovalid),          32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1, 0, 4'd1, 1, 1, 8'h00, 0, 8'h00, 8'h00, 8'h10, 8'h60);
    chk("retain_wb",    32'(owb_data), 32'hA5);
    chk("retain_valid", 32'(ovalid),   32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register for the 8-bit TISC core. It consumes the EX/MEM register outputs, owns the 256×8 data memory, performs stores, and resolves loads. It then registers the selected write-back value, destination register and next PC for the register-file write in the WB stage. One cycle separates EX/MEM outputs from WB outputs.

## Interface
- DEPTH, 256: data memory words; addresses are 8 bits, so DEPTH is fixed at 256.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  stage advance; 0 = stall (hold everything, no store)
- flush  in  1  bubble insert; wins over en for the WB control outputs
- ireg_write_addr  in  4  destination register from EX/MEM
- ireg_write_en  in  1  register write enable from EX/MEM
- imem_to_reg  in  1  1 = write back load data; 0 = write back ALU result
- ialu_out  in  8  ALU result
- imem_write_en  in  1  store enable
- idata_write_addr  in  8  store address
- idata_write_data  in  8  store data
- idata_read_addr  in  8  load address
- inextPC  in  8  next PC of the instruction
- oreg_write_addr  out  4  registered destination register
- oreg_write_en  out  1  registered write enable
- owb_data  out  8  registered write-back value
- onextPC  out  8  registered next PC
- ovalid  out  1  1 = WB slot holds a real instruction (not a bubble or reset)

## Operation
- Data memory: 256×8 array, one synchronous write port and one synchronous read port. Memory contents are not reset.
- Store: at a rising edge with en=1, flush=0 and imem_write_en=1, mem[idata_write_addr] <= idata_write_data.
- Load path: at a rising edge with en=1, the stage samples mem[idata_read_addr] for use in owb_data.
- Read-during-write: if the store and load address match in the same cycle, the load sees the new data (write-first). Store data bypasses the array.
- Write-back mux, evaluated at the edge:
  - owb_data <= imem_to_reg ? load_data : ialu_out
  - load_data is the bypassed value if an address match occurs.
- Address and data arithmetic: none. All 8-bit values pass through unmodified, with no extension or wrap logic.
- Register update when en=1 and flush=0:
  - all outputs load from their inputs and the mux
  - ovalid <= 1
- flush=1 (regardless of en):
  - oreg_write_en <= 0 and ovalid <= 0
  - store suppressed
  - oreg_write_addr, owb_data and onextPC load as normal (don't-care to consumers)
- en=0, flush=0:
  - all outputs hold
  - memory unchanged
  - a pending store is not performed; it is re-presented by upstream when the stall releases
- Reset (rst_n=0, asynchronous): oreg_write_addr=0, oreg_write_en=0, owb_data=0, onextPC=0, ovalid=0. No store occurs while rst_n=0.
- Reset release is synchronous to clk via normal sampling. The first edge with rst_n=1 and en=1 captures inputs.

## Timing
- Latency: inputs at edge N appear on outputs after edge N (one cycle). A store at edge N is readable by a load sampled at edge N (bypass) or at any later edge.
- Back-to-back stores and loads every cycle are supported; throughput is one instruction per cycle.
- Reset asserted mid-operation: outputs clear immediately without a clock. A store coincident with the asserting edge is not guaranteed. Memory retains earlier stores.
- Simultaneous flush and en=0: flush wins, so the WB slot becomes a bubble and the other outputs hold or load (don't-care).
- Outputs are purely registered: no combinational path from any input to any output.

## Test plan
- Reset: drive rst_n=0 mid-cycle with outputs nonzero -> all five outputs read 0 before the next edge. ovalid=0.
- Store then load:
  - edge 1: store 0xA5 to 0x10
  - edge 2: load 0x10 with imem_to_reg=1, ireg_write_addr=3
  - -> owb_data=0xA5, oreg_write_addr=3, oreg_write_en=1, ovalid=1
- Write-first bypass: same edge, store 0x3C to 0xFF and load 0xFF with imem_to_reg=1 -> owb_data=0x3C. A later load of 0xFF also returns 0x3C.
- ALU path: imem_to_reg=0, ialu_out=0x7E, inextPC=0x21 -> owb_data=0x7E, onextPC=0x21 one cycle later.
- Stall: en=0 for 3 cycles with imem_write_en=1 to 0x20 (data 0x55) -> outputs hold and mem[0x20] is unchanged (a load after release returns the old value 0x00 from a pre-written location).
- Flush: flush=1 with ireg_write_en=1 and imem_write_en=1 to 0x30 -> oreg_write_en=0, ovalid=0, and mem[0x30] is unchanged.
